// File: rtl/nios_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package nios_vjtag_pkg;
  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  localparam logic [1:0] IR_MONITOR   = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RESP
  } vjtag_state_e;
endpackage

// File: rtl/vjtag_tck_gen.sv
// Divided test clock: TCK_DIV clk cycles low, then TCK_DIV high, with edge strobes.
module vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise_en,
  output logic fall_en
);
  localparam int DW = $clog2(TCK_DIV + 1);

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap    = en && (div == DW'(TCK_DIV - 1));
  assign rise_en = wrap && !tck;
  assign fall_en = wrap && tck;

  // Disabled means parked: tck low and the divider rearmed for a fresh low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      div <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + 1'b1;
    end
  end
endmodule

// File: rtl/nios_vjtag_scan_master.sv
// Drives one virtual-JTAG scan (UIR, CDR, SDR x DR_WIDTH, UDR) per command and returns the captured DR.
module nios_vjtag_scan_master
  import nios_vjtag_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int CW = $clog2(DR_WIDTH + 1);

  vjtag_state_e        state, state_nx;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [CW-1:0]       bit_cnt;
  logic                accept, tck_en, rise_en, fall_en;

  assign rsp_valid = (state == ST_RESP);
  assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign tck_en    = state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR};

  assign vji_rti = (state == ST_IDLE) || (state == ST_RESP);
  assign vji_uir = (state == ST_UIR);
  assign vji_cdr = (state == ST_CDR);
  assign vji_sdr = (state == ST_SDR);
  assign vji_udr = (state == ST_UDR);

  vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tck_en),
    .tck     (vji_tck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)                        state_nx = ST_UIR;
      ST_UIR:  if (fall_en)                       state_nx = ST_CDR;
      ST_CDR:  if (fall_en)                       state_nx = ST_SDR;
      ST_SDR:  if (fall_en && (bit_cnt == '0))    state_nx = ST_UDR;
      ST_UDR:  if (fall_en)                       state_nx = ST_RESP;
      ST_RESP: if (rsp_ready)                     state_nx = ST_IDLE;
      default:                                    state_nx = ST_IDLE;
    endcase
  end

  // tdi is re-registered on falls so the slave sees it stable across every rise,
  // even though shift_reg itself moves on the rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      vji_ir_in  <= '0;
      vji_tdi    <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vji_ir_in <= cmd_ir;
        shift_reg <= cmd_dr;
      end
      if ((state == ST_SDR) && rise_en)
        shift_reg <= {vji_tdo, shift_reg[DR_WIDTH-1:1]};
      if ((state == ST_UDR) && rise_en)
        rsp_ir_out <= vji_ir_out;
      if (fall_en) begin
        case (state)
          ST_CDR: begin
            bit_cnt <= CW'(DR_WIDTH - 1);
            vji_tdi <= shift_reg[0];
          end
          ST_SDR: begin
            if (bit_cnt == '0) begin
              vji_tdi <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              vji_tdi <= shift_reg[0];
            end
          end
          ST_UDR:  rsp_dr <= shift_reg;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nios_vjtag_scan_master.sv
// Bench for nios_vjtag_scan_master: slave DR model, vector table, random scans and corner sequences.
module tb_nios_vjtag_scan_master;
  localparam int DW    = 38;
  localparam int IW    = 2;
  localparam int LAT_A = 2 * 2 * (DW + 3) + 1;
  localparam int LAT_B = 2 * 1 * (DW + 3) + 1;
  localparam int NVEC  = 8;

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] dr;
    logic [DW-1:0] pre;
    logic [IW-1:0] iro;
    logic [DW-1:0] exp_dr;
    logic [IW-1:0] exp_ir;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default TCK_DIV=2
  logic          a_cmd_valid = 0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 0;
  logic [IW-1:0] a_cmd_ir = '0, a_rsp_ir, a_ir_in, a_ir_out = '0;
  logic [DW-1:0] a_cmd_dr = '0, a_rsp_dr;
  logic          a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;

  nios_vjtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_ir(a_cmd_ir), .cmd_dr(a_cmd_dr), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_dr(a_rsp_dr), .rsp_ir_out(a_rsp_ir), .vji_tck(a_tck), .vji_tdi(a_tdi),
    .vji_tdo(a_tdo), .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out), .vji_uir(a_uir),
    .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti));

  // DUT B: TCK_DIV=1 build
  logic          b_cmd_valid = 0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 0;
  logic [IW-1:0] b_cmd_ir = '0, b_rsp_ir, b_ir_in, b_ir_out = '0;
  logic [DW-1:0] b_cmd_dr = '0, b_rsp_dr;
  logic          b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;

  nios_vjtag_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_dr(b_cmd_dr), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir), .vji_tck(b_tck), .vji_tdi(b_tdi),
    .vji_tdo(b_tdo), .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out), .vji_uir(b_uir),
    .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti));

  // Debug-slave models: DR captures a preset on the CDR rise, shifts tdi in on each SDR rise.
  logic [DW-1:0] a_mdr = '0, a_pre = '0, b_mdr = '0, b_pre = '0;
  assign a_tdo = a_mdr[0];
  assign b_tdo = b_mdr[0];
  always @(posedge a_tck)
    if (a_cdr) a_mdr <= a_pre; else if (a_sdr) a_mdr <= {a_tdi, a_mdr[DW-1:1]};
  always @(posedge b_tck)
    if (b_cdr) b_mdr <= b_pre; else if (b_sdr) b_mdr <= {b_tdi, b_mdr[DW-1:1]};

  // Protocol monitor on DUT A, cumulative counters sampled mid-cycle.
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rise = 0, n_viol = 0, n_irbad = 0;
  logic [IW-1:0] exp_ir = '0;
  logic          p_tck = 0;
  logic [4:0]    p_fl = '0;
  always @(negedge clk) begin
    logic [4:0] fl;
    fl = {a_uir, a_cdr, a_sdr, a_udr, a_tdi};
    n_uir += int'(a_uir); n_cdr += int'(a_cdr); n_sdr += int'(a_sdr); n_udr += int'(a_udr);
    if (!p_tck && a_tck) n_rise++;
    if (($countones(fl[4:1]) > 1) || ((fl != p_fl) && a_tck)) n_viol++;
    if (!a_rti && (a_ir_in !== exp_ir)) n_irbad++;
    p_tck = a_tck;
    p_fl  = fl;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] a_outs();
    return {a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti,
            a_rsp_valid, a_rsp_dr, a_rsp_ir, a_cmd_ready};
  endfunction
  localparam logic [63:0] A_RST = {1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 38'h0, 2'b00, 1'b1};

  task automatic wait_rsp_a(input int t0, output int lat);
    int k;
    k = 0;
    while (!a_rsp_valid && k < 1000) begin @(negedge clk); k++; end
    if (!a_rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, required one", k);
    end
    lat = cyc - t0;
  endtask

  task automatic run_a(input string tag, input vec_t v);
    int t0, lat, s_u, s_c, s_s, s_d, s_r, s_v, s_i;
    @(negedge clk);
    a_pre = v.pre; a_ir_out = v.iro; exp_ir = v.ir;
    a_cmd_ir = v.ir; a_cmd_dr = v.dr; a_cmd_valid = 1;
    chk({tag, "_ready"}, a_cmd_ready, 1);
    t0 = cyc;
    s_u = n_uir; s_c = n_cdr; s_s = n_sdr; s_d = n_udr; s_r = n_rise; s_v = n_viol; s_i = n_irbad;
    @(negedge clk);
    a_cmd_valid = 0;
    chk({tag, "_busy"}, a_cmd_ready, 0);
    wait_rsp_a(t0, lat);
    chk({tag, "_lat"}, lat, LAT_A);
    chk({tag, "_rsp_dr"}, a_rsp_dr, v.exp_dr);
    chk({tag, "_rsp_ir"}, a_rsp_ir, v.exp_ir);
    chk({tag, "_slave_dr"}, a_mdr, v.dr);
    chk({tag, "_flags"}, {16'(n_uir - s_u), 16'(n_cdr - s_c), 16'(n_sdr - s_s), 16'(n_udr - s_d)},
        {16'd4, 16'd4, 16'(4 * DW), 16'd4});
    chk({tag, "_rises"}, n_rise - s_r, DW + 3);
    chk({tag, "_proto"}, n_viol - s_v, 0);
    chk({tag, "_ir_in"}, n_irbad - s_i, 0);
    a_rsp_ready = 1;
    @(negedge clk);
    a_rsp_ready = 0;
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v.ir  = IW'($urandom_range(0, 3));
    v.iro = IW'($urandom_range(0, 3));
    v.dr  = DW'({$urandom(), $urandom()});
    v.pre = DW'({$urandom(), $urandom()});
    v.exp_dr = v.pre;
    v.exp_ir = v.iro;
    return v;
  endfunction

  vec_t tbl[NVEC];

  initial begin
    vec_t v, v2;
    int k, t0, h, lat, bad, nr;
    logic pt;
    logic [DW-1:0] d0;

    tbl[0] = '{2'b00, 38'h15_0000_FFFF, 38'h2A_5A5A_5A5A, 2'b00, 38'h2A_5A5A_5A5A, 2'b00};
    tbl[1] = '{2'b11, 38'h01_2345_6789, 38'h3F_0F0F_0F0F, 2'b10, 38'h3F_0F0F_0F0F, 2'b10};
    tbl[2] = '{2'b01, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b01, 38'h00_0000_0000, 2'b01};
    tbl[3] = '{2'b10, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b11, 38'h3F_FFFF_FFFF, 2'b11};
    for (int i = 4; i < NVEC; i++) tbl[i] = rnd_vec();

    repeat (3) @(negedge clk);
    chk("reset_state", a_outs(), A_RST);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", a_outs(), A_RST);

    for (int i = 0; i < NVEC; i++) run_a($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: response held, new command presented but not accepted.
    v = rnd_vec(); v2 = rnd_vec();
    @(negedge clk);
    a_pre = v.pre; a_ir_out = v.iro; exp_ir = v.ir; a_cmd_ir = v.ir; a_cmd_dr = v.dr; a_cmd_valid = 1;
    t0 = cyc;
    @(negedge clk);
    a_cmd_valid = 0;
    wait_rsp_a(t0, lat);
    d0 = a_rsp_dr;
    chk("bp_first_dr", d0, v.exp_dr);
    a_cmd_ir = v2.ir; a_cmd_dr = v2.dr; a_cmd_valid = 1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_cmd_ready !== 1'b0 || a_rsp_dr !== d0 || a_rsp_valid !== 1'b1) bad++;
    end
    chk("bp_hold", bad, 0);
    a_pre = v2.pre; a_ir_out = v2.iro; exp_ir = v2.ir;
    a_rsp_ready = 1;
    h = cyc;
    @(negedge clk);
    a_rsp_ready = 0;
    chk("bp_after_hs", {a_rsp_valid, a_cmd_ready}, 2'b01);
    @(negedge clk);
    a_cmd_valid = 0;
    chk("bp_accept_next", {a_uir, a_cmd_ready}, 2'b10);
    wait_rsp_a(h + 1, lat);
    chk("bp_second_lat", lat, LAT_A);
    chk("bp_second_dr", a_rsp_dr, v2.exp_dr);
    a_rsp_ready = 1;
    @(negedge clk);
    a_rsp_ready = 0;

    // Reset at the 10th SDR rise.
    @(negedge clk);
    a_pre = 38'h11_2233_4455; a_ir_out = 2'b11; exp_ir = 2'b01;
    a_cmd_ir = 2'b01; a_cmd_dr = 38'h0A_BCDE_F012; a_cmd_valid = 1;
    @(negedge clk);
    a_cmd_valid = 0;
    nr = 0; k = 0; pt = 0;
    while (nr < 10 && k < 500) begin
      @(negedge clk);
      k++;
      if (a_sdr && a_tck && !pt) nr++;
      pt = a_tck;
    end
    chk("rst_reached_sdr", nr, 10);
    reset_n = 0;
    #1;
    chk("rst_midscan_outputs", a_outs(), A_RST);
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_release_idle", {a_rti, a_cmd_ready, a_rsp_valid}, 3'b110);
    bad = 0;
    repeat (200) begin @(negedge clk); if (a_rsp_valid || !a_rti) bad++; end
    chk("rst_no_rsp", bad, 0);
    run_a("post_rst", tbl[0]);
    run_a("post_rst_rnd", rnd_vec());

    // TCK_DIV=1 build, basic scan.
    @(negedge clk);
    b_pre = 38'h2A_5A5A_5A5A; b_cmd_ir = 2'b00; b_cmd_dr = 38'h15_0000_FFFF; b_cmd_valid = 1;
    chk("b_ready", b_cmd_ready, 1);
    t0 = cyc;
    @(negedge clk);
    b_cmd_valid = 0;
    k = 0;
    while (!b_rsp_valid && k < 1000) begin @(negedge clk); k++; end
    chk("b_lat", cyc - t0, LAT_B);
    chk("b_rsp_dr", b_rsp_dr, 38'h2A_5A5A_5A5A);
    chk("b_slave_dr", b_mdr, 38'h15_0000_FFFF);
    b_rsp_ready = 1;
    @(negedge clk);
    b_rsp_ready = 0;
    @(negedge clk);
    chk("b_idle", {b_rsp_valid, b_cmd_ready, b_rti}, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
